// File: rtl/pokemon_select_ctrl.sv
// Character-select controller: a cursor on a ROWS x COLS grid picks player 1, and an LFSR draws player 2.
// Optional define POKE_NO_MIRROR_EN stops player 2 from drawing the same id as player 1.
module pokemon_select_ctrl #(
    parameter int         ROWS         = 2,
    parameter int         COLS         = 4,
    parameter bit         WRAP         = 1'b0,
    parameter logic [3:0] CHOOSE_SCENE = 4'b0010
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] scene_state,
    input  logic       key_U,
    input  logic       key_D,
    input  logic       key_L,
    input  logic       key_R,
    input  logic       key_C,
    output logic [7:0] cursor_id,
    output logic [7:0] p1_pokemon_id,
    output logic [7:0] p1_pokemon_hp,
    output logic [7:0] p1_pokemon_speed,
    output logic [7:0] p1_skill_1_damage,
    output logic [7:0] p1_skill_2_damage,
    output logic [7:0] p1_skill_3_damage,
    output logic [7:0] p2_pokemon_id,
    output logic [7:0] p2_pokemon_hp,
    output logic [7:0] p2_pokemon_speed,
    output logic [7:0] p2_skill_1_damage,
    output logic [7:0] p2_skill_2_damage,
    output logic [7:0] p2_skill_3_damage,
    output logic       sel_done
);

    localparam logic [7:0] NUM_IDS  = 8'(ROWS * COLS);
    localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);
    localparam logic [3:0] LAST_COL = 4'(COLS - 1);

    typedef enum logic [1:0] {IDLE, BROWSE, PICK, DONE} state_e;

    typedef struct packed {
        logic [7:0] hp;
        logic [7:0] speed;
        logic [7:0] skill1;
        logic [7:0] skill2;
        logic [7:0] skill3;
    } stats_t;

    function automatic stats_t statsOf(input logic [7:0] id);
        stats_t s;
        case (id)
            8'd1:    s = {8'd50,  8'd250, 8'd31, 8'd25, 8'd34};
            8'd2:    s = {8'd60,  8'd225, 8'd35, 8'd31, 8'd47};
            8'd3:    s = {8'd70,  8'd200, 8'd37, 8'd29, 8'd45};
            8'd4:    s = {8'd90,  8'd175, 8'd17, 8'd89, 8'd23};
            8'd5:    s = {8'd100, 8'd150, 8'd44, 8'd55, 8'd65};
            8'd6:    s = {8'd120, 8'd125, 8'd40, 8'd17, 8'd67};
            8'd7:    s = {8'd150, 8'd100, 8'd45, 8'd40, 8'd54};
            8'd8:    s = {8'd160, 8'd75,  8'd64, 8'd64, 8'd64};
            default: s = '0;
        endcase
        return s;
    endfunction

    state_e     state_q, state_d;
    logic [3:0] row_q, row_d, col_q, col_d;
    logic [7:0] cursor_q, cursor_d;
    stats_t     p1Stats_q, p1Stats_d;
    logic [7:0] p2Id_q, p2Id_d;
    stats_t     p2Stats_q, p2Stats_d;
    logic       selDone_q, selDone_d;
    logic [4:0] keySample_q, keyPrev_q;
    logic [7:0] lfsr_q, lfsr_d;

    logic [4:0] keyEvent;
    logic       singleEvent;
    logic [7:0] candidate;
    logic       candidateOk;

    // Keys are registered once before edge detection, giving the one-cycle move latency.
    assign keyEvent    = keySample_q & ~keyPrev_q;
    assign singleEvent = $onehot(keyEvent);
    assign candidate   = {5'd0, lfsr_q[2:0]} + 8'd1;
    assign lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

`ifdef POKE_NO_MIRROR_EN
    assign candidateOk = (candidate <= NUM_IDS) && (candidate != cursor_q);
`else
    assign candidateOk = (candidate <= NUM_IDS);
`endif

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        p2Id_d    = p2Id_q;
        p2Stats_d = p2Stats_q;
        selDone_d = selDone_q;
        if (scene_state != CHOOSE_SCENE) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d   = BROWSE;
                    row_d     = '0;
                    col_d     = '0;
                    p2Id_d    = '0;
                    p2Stats_d = '0;
                    selDone_d = 1'b0;
                end
                BROWSE: begin
                    if (singleEvent) begin
                        if (keyEvent[0]) begin
                            if (row_q != 4'd0) row_d = row_q - 4'd1;
                            else if (WRAP)     row_d = LAST_ROW;
                        end else if (keyEvent[1]) begin
                            if (row_q != LAST_ROW) row_d = row_q + 4'd1;
                            else if (WRAP)         row_d = 4'd0;
                        end else if (keyEvent[2]) begin
                            if (col_q != 4'd0) col_d = col_q - 4'd1;
                            else if (WRAP)     col_d = LAST_COL;
                        end else if (keyEvent[3]) begin
                            if (col_q != LAST_COL) col_d = col_q + 4'd1;
                            else if (WRAP)         col_d = 4'd0;
                        end else begin
                            state_d = PICK;
                        end
                    end
                end
                PICK: begin
                    if (candidateOk) begin
                        p2Id_d    = candidate;
                        p2Stats_d = statsOf(candidate);
                        selDone_d = 1'b1;
                        state_d   = DONE;
                    end
                end
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
        // Player 1 always mirrors the cursor, so its stats simply track the next cursor id.
        cursor_d  = 8'(32'(row_d) * COLS + 32'(col_d) + 1);
        p1Stats_d = statsOf(cursor_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            cursor_q    <= 8'd1;
            p1Stats_q   <= statsOf(8'd1);
            p2Id_q      <= '0;
            p2Stats_q   <= '0;
            selDone_q   <= 1'b0;
            keySample_q <= '0;
            keyPrev_q   <= '0;
            lfsr_q      <= 8'hA5;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            cursor_q    <= cursor_d;
            p1Stats_q   <= p1Stats_d;
            p2Id_q      <= p2Id_d;
            p2Stats_q   <= p2Stats_d;
            selDone_q   <= selDone_d;
            keySample_q <= {key_C, key_R, key_L, key_D, key_U};
            keyPrev_q   <= keySample_q;
            lfsr_q      <= lfsr_d;
        end
    end

    assign cursor_id         = cursor_q;
    assign p1_pokemon_id     = cursor_q;
    assign p1_pokemon_hp     = p1Stats_q.hp;
    assign p1_pokemon_speed  = p1Stats_q.speed;
    assign p1_skill_1_damage = p1Stats_q.skill1;
    assign p1_skill_2_damage = p1Stats_q.skill2;
    assign p1_skill_3_damage = p1Stats_q.skill3;
    assign p2_pokemon_id     = p2Id_q;
    assign p2_pokemon_hp     = p2Stats_q.hp;
    assign p2_pokemon_speed  = p2Stats_q.speed;
    assign p2_skill_1_damage = p2Stats_q.skill1;
    assign p2_skill_2_damage = p2Stats_q.skill2;
    assign p2_skill_3_damage = p2Stats_q.skill3;
    assign sel_done          = selDone_q;

endmodule

// File: tb/tb_pokemon_select_ctrl.sv
// Bench for pokemon_select_ctrl: three configurations (2x4 clamp, 2x4 wrap, 2x3 clamp) share one stimulus
// stream and are checked every cycle against a grid/LFSR model, plus hand-computed literal expectations.
module tb_pokemon_select_ctrl;

    localparam logic [3:0] CH   = 4'b0010;
    localparam int         NDUT = 3;
    localparam logic [4:0] KU = 5'b00001, KD = 5'b00010, KL = 5'b00100, KR = 5'b01000, KC = 5'b10000;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] scene = 4'd0;
    logic [4:0] keys  = 5'd0;

    always #5 clk = ~clk;

    logic [7:0] curO [NDUT], p1IdO[NDUT], p1HpO[NDUT], p1SpO[NDUT], p1S1O[NDUT], p1S2O[NDUT], p1S3O[NDUT];
    logic [7:0] p2IdO[NDUT], p2HpO[NDUT], p2SpO[NDUT], p2S1O[NDUT], p2S2O[NDUT], p2S3O[NDUT];
    logic       selO [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : gDut
        pokemon_select_ctrl #(
            .ROWS(2), .COLS(g == 2 ? 3 : 4), .WRAP(g == 1), .CHOOSE_SCENE(CH)
        ) dut (
            .clk(clk), .reset(reset), .scene_state(scene),
            .key_U(keys[0]), .key_D(keys[1]), .key_L(keys[2]), .key_R(keys[3]), .key_C(keys[4]),
            .cursor_id(curO[g]), .p1_pokemon_id(p1IdO[g]),
            .p1_pokemon_hp(p1HpO[g]), .p1_pokemon_speed(p1SpO[g]),
            .p1_skill_1_damage(p1S1O[g]), .p1_skill_2_damage(p1S2O[g]), .p1_skill_3_damage(p1S3O[g]),
            .p2_pokemon_id(p2IdO[g]),
            .p2_pokemon_hp(p2HpO[g]), .p2_pokemon_speed(p2SpO[g]),
            .p2_skill_1_damage(p2S1O[g]), .p2_skill_2_damage(p2S2O[g]), .p2_skill_3_damage(p2S3O[g]),
            .sel_done(selO[g])
        );
    end

    int hpTab[9] = '{0, 50, 60, 70, 90, 100, 120, 150, 160};
    int spTab[9] = '{0, 250, 225, 200, 175, 150, 125, 100, 75};
    int s1Tab[9] = '{0, 31, 35, 37, 17, 44, 40, 45, 64};
    int s2Tab[9] = '{0, 25, 31, 29, 89, 55, 17, 40, 64};
    int s3Tab[9] = '{0, 34, 47, 45, 23, 65, 67, 54, 64};

    int mRows[NDUT] = '{2, 2, 2};
    int mCols[NDUT] = '{4, 4, 3};
    bit mWrap[NDUT] = '{1'b0, 1'b1, 1'b0};

    int checkCount = 0;
    int passCount  = 0;

    function automatic logic [39:0] expStats(input int id);
        if (id < 1 || id > 8) return 40'd0;
        return {8'(hpTab[id]), 8'(spTab[id]), 8'(s1Tab[id]), 8'(s2Tab[id]), 8'(s3Tab[id])};
    endfunction

    // Model state: mode 0 idle, 1 browsing, 2 drawing, 3 done; cursor kept as grid row/column.
    int         mMode[NDUT], mRow[NDUT], mCol[NDUT], mP2[NDUT];
    bit         mSel[NDUT];
    logic [7:0] mLfsr;
    logic [4:0] mSample, mPrev;
    bit         modelValid = 1'b0;

    always @(posedge clk) begin : model
        logic [4:0] ev;
        int         cand, n, r, c, cur;
        bit         ok;
        if (reset) begin
            for (int i = 0; i < NDUT; i++) begin
                mMode[i] = 0; mRow[i] = 0; mCol[i] = 0; mP2[i] = 0; mSel[i] = 1'b0;
            end
            mLfsr = 8'hA5; mSample = '0; mPrev = '0;
            modelValid = 1'b1;
        end else begin
            ev   = mSample & ~mPrev;
            cand = int'(mLfsr % 8) + 1;
            for (int i = 0; i < NDUT; i++) begin
                r = mRows[i]; c = mCols[i]; n = r * c;
                cur = mRow[i] * c + mCol[i] + 1;
                if (scene != CH) begin
                    mMode[i] = 0;
                end else if (mMode[i] == 0) begin
                    mMode[i] = 1; mRow[i] = 0; mCol[i] = 0; mP2[i] = 0; mSel[i] = 1'b0;
                end else if (mMode[i] == 1 && $countones(ev) == 1) begin
                    if (ev[0])      mRow[i] = mWrap[i] ? (mRow[i] + r - 1) % r : (mRow[i] > 0 ? mRow[i] - 1 : 0);
                    else if (ev[1]) mRow[i] = mWrap[i] ? (mRow[i] + 1) % r : (mRow[i] < r - 1 ? mRow[i] + 1 : mRow[i]);
                    else if (ev[2]) mCol[i] = mWrap[i] ? (mCol[i] + c - 1) % c : (mCol[i] > 0 ? mCol[i] - 1 : 0);
                    else if (ev[3]) mCol[i] = mWrap[i] ? (mCol[i] + 1) % c : (mCol[i] < c - 1 ? mCol[i] + 1 : mCol[i]);
                    else            mMode[i] = 2;
                end else if (mMode[i] == 2) begin
                    ok = (cand <= n);
`ifdef POKE_NO_MIRROR_EN
                    ok = ok && (cand != cur);
`endif
                    if (ok) begin
                        mP2[i] = cand; mSel[i] = 1'b1; mMode[i] = 3;
                    end
                end
            end
            mPrev   = mSample;
            mSample = keys;
            mLfsr   = {mLfsr[6:0], ^(mLfsr & 8'hB8)};
        end
    end

    always @(negedge clk) begin : compare
        logic [104:0] got, expv;
        int           cur;
        if (modelValid) begin
            for (int i = 0; i < NDUT; i++) begin
                cur  = mRow[i] * mCols[i] + mCol[i] + 1;
                expv = {8'(cur), 8'(cur), expStats(cur), 8'(mP2[i]), expStats(mP2[i]), mSel[i]};
                got  = {curO[i], p1IdO[i], p1HpO[i], p1SpO[i], p1S1O[i], p1S2O[i], p1S3O[i],
                        p2IdO[i], p2HpO[i], p2SpO[i], p2S1O[i], p2S2O[i], p2S3O[i], selO[i]};
                checkCount++;
                if (got === expv) passCount++;
                else $display("[TB] FAIL model_dut%0d at %0t: got %h, expected %h", i, $time, got, expv);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] expv);
        checkCount++;
        if (got === expv) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, got, expv);
    endtask

    task automatic applyStimulus(input logic [4:0] k, input int hold);
        keys = k;
        repeat (hold) tick();
        keys = '0;
        repeat (3) tick();
    endtask

    task automatic enterChoose();
        scene = 4'd0;
        tick();
        scene = CH;
        tick();
        tick();
    endtask

    task automatic pressConfirm();
        keys = KC;
        tick();
        keys = '0;
        tick();
    endtask

    logic [4:0] moves[5] = '{KR, KR, KR, KD, KR};
    int         exp0[5]  = '{2, 3, 4, 8, 8};
    int         exp1[5]  = '{2, 3, 4, 8, 5};
    int         exp2[5]  = '{2, 3, 3, 6, 6};
    logic [4:0] wmoves[3] = '{KL, KU, KD};
    int         wexp1[3]  = '{4, 8, 4};
    int         wexp2[3]  = '{1, 1, 4};

    initial begin
        int runs;
        bit done;
        reset = 1'b1;
        repeat (3) tick();
        checkOutput("reset_cursor", 32'(curO[0]), 1);
        checkOutput("reset_p1_hp", 32'(p1HpO[0]), 50);
        checkOutput("reset_p1_speed", 32'(p1SpO[0]), 250);
        checkOutput("reset_p1_skill3", 32'(p1S3O[0]), 34);
        checkOutput("reset_p2_id", 32'(p2IdO[0]), 0);
        checkOutput("reset_sel_done", 32'(selO[0]), 0);

        reset = 1'b0;
        scene = CH;
        tick();
        tick();
        checkOutput("entry_cursor", 32'(curO[0]), 1);
        checkOutput("entry_p1_hp", 32'(p1HpO[0]), 50);
        checkOutput("entry_p1_speed", 32'(p1SpO[0]), 250);
        checkOutput("entry_p2_id", 32'(p2IdO[0]), 0);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(moves[i], 1);
            checkOutput($sformatf("clamp_move%0d", i), 32'(curO[0]), 32'(exp0[i]));
            checkOutput($sformatf("wrap_move%0d", i), 32'(curO[1]), 32'(exp1[i]));
            checkOutput($sformatf("grid6_move%0d", i), 32'(curO[2]), 32'(exp2[i]));
        end
        checkOutput("clamp_p1_hp", 32'(p1HpO[0]), 160);
        checkOutput("clamp_p1_skill2", 32'(p1S2O[0]), 64);

        enterChoose();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(wmoves[i], 1);
            checkOutput($sformatf("wrap_edge%0d", i), 32'(curO[1]), 32'(wexp1[i]));
            checkOutput($sformatf("grid6_edge%0d", i), 32'(curO[2]), 32'(wexp2[i]));
        end
        checkOutput("clamp_after_edges", 32'(curO[0]), 5);

        applyStimulus(KR, 10);
        checkOutput("hold_r_single_move", 32'(curO[0]), 6);
        checkOutput("hold_r_wrap", 32'(curO[1]), 1);
        applyStimulus(KU | KR, 1);
        checkOutput("dual_key_ignored", 32'(curO[0]), 6);
        checkOutput("dual_key_ignored_grid6", 32'(curO[2]), 5);

        // Leave the scene one edge after the confirm has put every instance into the draw.
        enterChoose();
        pressConfirm();
        scene = 4'd0;
        repeat (4) tick();
        for (int i = 0; i < NDUT; i++)
            checkOutput($sformatf("leave_mid_pick_sel%0d", i), 32'(selO[i]), 0);

        enterChoose();
        applyStimulus(KD, 1);
        pressConfirm();
        reset = 1'b1;
        tick();
        checkOutput("reset_mid_pick_cursor", 32'(curO[0]), 1);
        checkOutput("reset_mid_pick_p1_hp", 32'(p1HpO[0]), 50);
        checkOutput("reset_mid_pick_p2_id", 32'(p2IdO[0]), 0);
        checkOutput("reset_mid_pick_sel", 32'(selO[0]), 0);
        reset = 1'b0;
        tick();

`ifdef POKE_NO_MIRROR_EN
        runs = 50;
`else
        runs = 4;
`endif
        for (int r = 0; r < runs; r++) begin
            enterChoose();
            applyStimulus(KD, 1);
            checkOutput("pick_cursor", 32'(curO[0]), 5);
            pressConfirm();
            done = 1'b0;
            for (int c = 0; c < 300 && !done; c++) begin
                if (selO[0]) done = 1'b1;
                else tick();
            end
            checkOutput("pick_within_bound", 32'(done), 1);
            checkOutput("pick_p2_in_range", 32'(p2IdO[0] >= 8'd1 && p2IdO[0] <= 8'd8), 1);
            checkOutput("grid6_p2_not_7_or_8", 32'(selO[2] && p2IdO[2] > 8'd6), 0);
`ifdef POKE_NO_MIRROR_EN
            checkOutput("no_mirror_p2_not_5", 32'(p2IdO[0] == 8'd5), 0);
`endif
        end

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/pokemon_select_ctrl.md
# pokemon_select_ctrl

Parametrised character-select controller for the choose scene. It moves a cursor over a configurable ROWS×COLS grid from edge-detected direction keys, with either clamped or wrapping edges. On confirm it locks the player-1 pick and draws the player-2 pick from a free-running LFSR with reject-and-retry. It then presents both picks' stat records to the fight logic with a `sel_done` flag. It sits between the scene FSM and the fight data path, and replaces the fixed 2×4 chooser.

## Interface
- `ROWS`, default 2: grid rows; ROWS×COLS = N, legal range 2..8.
- `COLS`, default 4: grid columns.
- `WRAP`, default 0: 0 = cursor clamps at grid edges; 1 = cursor wraps within its row or column.
- `CHOOSE_SCENE`, default 4'b0010: `scene_state` code for the choose scene.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `scene_state`  in  4  current scene code.
- `key_U`, `key_D`, `key_L`, `key_R`, `key_C`  in  1 each  debounced key levels.
- `cursor_id`  out  8  highlighted id, 1..N, for the display.
- `p1_pokemon_id`, `p2_pokemon_id`  out  8 each  selected ids; 0 means none.
- `p1_pokemon_hp`, `p1_pokemon_speed`, `p1_skill_1_damage`, `p1_skill_2_damage`, `p1_skill_3_damage`  out  8 each  player-1 stats.
- `p2_*` (same five fields)  out  8 each  player-2 stats.
- `sel_done`  out  1  level; both picks valid.

## Operation
- Stat table (id 1..8):
  - hp: 50, 60, 70, 90, 100, 120, 150, 160.
  - speed: 250, 225, 200, 175, 150, 125, 100, 75.
  - skill1: 31, 35, 37, 17, 44, 40, 45, 64.
  - skill2: 25, 31, 29, 89, 55, 17, 40, 64.
  - skill3: 34, 47, 45, 23, 65, 67, 54, 64.
- Key handling:
  - Each key has a registered previous-value bit; an event is a rising edge, i.e. key = 1 now and 0 in the previous cycle.
  - A cycle with more than one key event is ignored entirely.
- Grid: id = row×COLS + col + 1, row-major.
  - U/D change the row by ∓1; L/R change the column by ∓1.
  - WRAP=0: a move off the edge leaves the cursor unchanged. WRAP=1: row wraps modulo ROWS, column wraps modulo COLS.
- LFSR: 8 bits, x^8+x^6+x^5+x^4+1, seed 8'hA5 on reset, steps every cycle in all states. Candidate id = `lfsr[2:0]` + 1.
- States:
  - IDLE, entered whenever `scene_state` ≠ `CHOOSE_SCENE`: all outputs hold.
  - IDLE→BROWSE when `scene_state` == `CHOOSE_SCENE`. On the entry edge: cursor = 1, p1 = id 1 with its stats, p2 id and stats = 0, `sel_done` = 0.
  - BROWSE: a direction event moves the cursor; p1 id and stats follow the cursor (live preview). A C event goes to PICK.
  - PICK: each cycle the candidate is tested. It is accepted if ≤ N (and see Configuration). Accept: load the p2 id and stats, `sel_done` = 1, go to DONE. Reject: stay in PICK. Keys are ignored.
  - DONE: keys ignored; outputs hold until the scene changes.
- Scene change in any state forces IDLE on the next edge; no output is cleared.
- Reset values: state IDLE, cursor 1, p1 id 1 with id-1 stats (50/250/31/25/34), p2 id and all p2 stats 0, `sel_done` 0, previous-key bits 0.

## Timing
- All outputs are registered.
- Key rising edge sampled at edge t: cursor and p1 outputs update at edge t+1 (one-cycle latency).
- C event at edge t: PICK at t+1; earliest `sel_done` at t+2.
- PICK is bounded: the LFSR is maximal-length, so acceptance occurs within 255 cycles.
- `sel_done` rises on the same edge that the p2 data loads, and never precedes valid p2 data.
- Reset mid-PICK or mid-BROWSE applies reset values at that edge.

## Configuration
- `POKE_NO_MIRROR_EN`: when defined, PICK also rejects a candidate equal to `p1_pokemon_id`, so p2 always differs from p1. When undefined, mirror matches are allowed.

## Test plan
- Reset, then enter choose: `cursor_id` = 1, p1 hp/speed = 50/250, p2 id = 0, `sel_done` = 0.
- WRAP=0, ROWS=2, COLS=4: press R ×3, then D, then R → cursor 2, 3, 4, 8, 8; p1 hp = 160, skill2 = 64.
- WRAP=1: from 1 press L → 4; press U → 8; press D → 4.
- Hold R for 10 cycles → exactly one move. Press U and R in the same cycle → no move.
- Press C on id 5 → PICK, then `sel_done` = 1 within 255 cycles; p2 id in 1..8 with matching table stats. Under `POKE_NO_MIRROR_EN`, over 50 runs p2 ≠ 5 every time.
- N=6 (ROWS=2, COLS=3): p2 id is never 7 or 8. Leave the choose scene mid-PICK → IDLE, `sel_done` stays 0.
